// File: rtl/pbs_turn_ctrl.sv
// Turn controller for a two-party battle: player half-turn, AI half-turn,
// accuracy checks, damage strobes, KO and turn-limit resolution.
module pbs_turn_ctrl #(
    parameter logic [7:0] MOVE_TIMEOUT = 8'd200,
    parameter logic [7:0] MAX_TURNS    = 8'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    input  logic [1:0] move_in,
    input  logic       new_game,
    input  logic [3:0] p_hp,
    input  logic [3:0] AI_hp,
    input  logic [3:0] accu,
    input  logic [3:0] roll,
    output logic [1:0] p_move,
    output logic       actr,
    output logic       target,
    output logic       stop,
    output logic       load_ai_hp,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic       move_ready,
    output logic       hit,
    output logic [7:0] turn_cnt,
    output logic       game_over,
    output logic       winner,
    output logic       draw
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_P_SET,
        S_P_EVAL,
        S_P_APPLY,
        S_P_CHK,
        S_AI_SET,
        S_AI_EVAL,
        S_AI_APPLY,
        S_AI_CHK,
        S_OVER
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic [1:0] r_p_move;
    logic       r_hit;
    logic [7:0] r_turn;
    logic       r_winner;
    logic       r_draw;

    logic       w_hit;
    logic       w_timeout;
    logic [7:0] w_turn_inc;

    assign w_hit      = (accu >= roll);
    assign w_timeout  = (r_wait == (MOVE_TIMEOUT - 8'd1));
    assign w_turn_inc = r_turn + 8'd1;

    assign p_move   = r_p_move;
    assign hit      = r_hit;
    assign turn_cnt = r_turn;
    assign winner   = r_winner;
    assign draw     = r_draw;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and Moore decode of selects/strobes
    always_comb begin
        w_next     = r_state;
        actr       = 1'b0;
        target     = 1'b0;
        stop       = 1'b0;
        load_ai_hp = 1'b0;
        app_ai_dmg = 1'b0;
        app_pl_dmg = 1'b0;
        move_ready = 1'b0;
        game_over  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                move_ready = 1'b1;
                if (move_valid || w_timeout) begin
                    w_next = S_P_SET;
                end
            end
            S_P_SET: begin
                target     = 1'b1;
                load_ai_hp = 1'b1;
                w_next     = S_P_EVAL;
            end
            S_P_EVAL: begin
                target = 1'b1;
                stop   = 1'b1;
                w_next = w_hit ? S_P_APPLY : S_AI_SET;
            end
            S_P_APPLY: begin
                target     = 1'b1;
                app_ai_dmg = 1'b1;
                w_next     = S_P_CHK;
            end
            S_P_CHK: begin
                w_next = (AI_hp == 4'd0) ? S_OVER : S_AI_SET;
            end
            S_AI_SET: begin
                actr   = 1'b1;
                w_next = S_AI_EVAL;
            end
            S_AI_EVAL: begin
                actr   = 1'b1;
                stop   = 1'b1;
                w_next = w_hit ? S_AI_APPLY : S_AI_CHK;
            end
            S_AI_APPLY: begin
                app_pl_dmg = 1'b1;
                w_next     = S_AI_CHK;
            end
            S_AI_CHK: begin
                if (p_hp == 4'd0) begin
                    w_next = S_OVER;
                end else if (w_turn_inc == MAX_TURNS) begin
                    w_next = S_OVER;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_OVER: begin
                game_over = 1'b1;
                if (new_game) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Idle wait counter: runs only while staying in idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= 8'd0;
        end else if (r_state == S_IDLE && w_next == S_IDLE) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= 8'd0;
        end
    end

    // Registered move, hit flag, turn counter and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_move <= 2'b00;
            r_hit    <= 1'b0;
            r_turn   <= 8'd0;
            r_winner <= 1'b0;
            r_draw   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (move_valid) begin
                        r_p_move <= move_in;
                    end else if (w_timeout) begin
                        r_p_move <= 2'b00;
                    end
                end
                S_P_EVAL, S_AI_EVAL: begin
                    r_hit <= w_hit;
                end
                S_P_CHK: begin
                    if (AI_hp == 4'd0) begin
                        r_winner <= 1'b1;
                        r_draw   <= 1'b0;
                    end
                end
                S_AI_CHK: begin
                    if (p_hp == 4'd0) begin
                        r_winner <= 1'b0;
                        r_draw   <= 1'b0;
                    end else begin
                        r_turn <= w_turn_inc;
                        if (w_turn_inc == MAX_TURNS) begin
                            r_winner <= (p_hp > AI_hp);
                            r_draw   <= (p_hp == AI_hp);
                        end
                    end
                end
                S_OVER: begin
                    if (new_game) begin
                        r_turn   <= 8'd0;
                        r_winner <= 1'b0;
                        r_draw   <= 1'b0;
                        r_hit    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Bench for pbs_turn_ctrl: a turn-script model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pbs_turn_ctrl;

    localparam logic [7:0] TO = 8'd4;
    localparam logic [7:0] MT = 8'd2;

    logic       clk;
    logic       rst;
    logic       move_valid;
    logic [1:0] move_in;
    logic       new_game;
    logic [3:0] p_hp;
    logic [3:0] AI_hp;
    logic [3:0] accu;
    logic [3:0] roll;
    logic [1:0] p_move;
    logic       actr;
    logic       target;
    logic       stop;
    logic       load_ai_hp;
    logic       app_ai_dmg;
    logic       app_pl_dmg;
    logic       move_ready;
    logic       hit;
    logic [7:0] turn_cnt;
    logic       game_over;
    logic       winner;
    logic       draw;

    pbs_turn_ctrl #(
        .MOVE_TIMEOUT(TO),
        .MAX_TURNS   (MT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .move_valid(move_valid),
        .move_in   (move_in),
        .new_game  (new_game),
        .p_hp      (p_hp),
        .AI_hp     (AI_hp),
        .accu      (accu),
        .roll      (roll),
        .p_move    (p_move),
        .actr      (actr),
        .target    (target),
        .stop      (stop),
        .load_ai_hp(load_ai_hp),
        .app_ai_dmg(app_ai_dmg),
        .app_pl_dmg(app_pl_dmg),
        .move_ready(move_ready),
        .hit       (hit),
        .turn_cnt  (turn_cnt),
        .game_over (game_over),
        .winner    (winner),
        .draw      (draw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       actr;
        logic       target;
        logic       stop;
        logic       load;
        logic       aid;
        logic       pld;
        logic       ready;
        logic       over;
        logic       hit;
        logic [7:0] turn;
        logic       win;
        logic       drw;
    } exp_t;

    exp_t       cur;
    exp_t       q[$];
    int         waitc;
    logic [1:0] m_pmove;
    int         checks = 0;
    int         errors = 0;

    // Expected outputs of one cycle, carrying registered results forward
    function automatic exp_t blank(input exp_t p);
        exp_t b;
        b      = '0;
        b.hit  = p.hit;
        b.turn = p.turn;
        b.win  = p.win;
        b.drw  = p.drw;
        return b;
    endfunction

    task automatic model_reset();
        cur       = '0;
        cur.ready = 1'b1;
        q.delete();
        waitc   = 0;
        m_pmove = 2'b00;
    endtask

    // Script of a whole turn from the datapath inputs held during it
    task automatic build_turn();
        exp_t       e;
        logic       ph;
        logic       ah;
        logic [7:0] t;
        ph = (accu >= roll);
        ah = (accu >= roll);
        e = blank(cur); e.target = 1; e.load = 1; q.push_back(e);
        e = blank(cur); e.target = 1; e.stop = 1; q.push_back(e);
        if (ph) begin
            e = blank(cur); e.hit = 1; e.target = 1; e.aid = 1;
            q.push_back(e);
            e = blank(cur); e.hit = 1; q.push_back(e);
            if (AI_hp == 4'd0) begin
                e = blank(cur); e.hit = 1; e.over = 1;
                e.win = 1; e.drw = 0;
                q.push_back(e);
                return;
            end
        end
        e = blank(cur); e.hit = ph; e.actr = 1; q.push_back(e);
        e.stop = 1; q.push_back(e);
        e = blank(cur); e.hit = ah;
        if (ah) begin
            e.pld = 1; q.push_back(e); e.pld = 0;
        end
        q.push_back(e);
        if (p_hp == 4'd0) begin
            e.over = 1; e.win = 0; e.drw = 0;
            q.push_back(e);
            return;
        end
        t = cur.turn + 8'd1;
        e.turn = t;
        if (t == MT) begin
            e.over = 1;
            e.win  = (p_hp > AI_hp);
            e.drw  = (p_hp == AI_hp);
        end else begin
            e.ready = 1;
        end
        q.push_back(e);
    endtask

    // Model advance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (cur.ready) begin
            if (move_valid || waitc == int'(TO) - 1) begin
                m_pmove = move_valid ? move_in : 2'b00;
                waitc   = 0;
                build_turn();
                cur = q.pop_front();
            end else begin
                waitc++;
            end
        end else if (cur.over && new_game) begin
            cur       = '0;
            cur.ready = 1'b1;
            waitc     = 0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        exp_t act;
        act = {actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg,
               move_ready, game_over, hit, turn_cnt, winner, draw};
        checks++;
        if (act !== cur) begin
            errors++;
            $display("FAIL model t=%0t got %h want %h", $time, act, cur);
        end
        checks++;
        if (p_move !== m_pmove) begin
            errors++;
            $display("FAIL p_move t=%0t got %0d want %0d",
                     $time, p_move, m_pmove);
        end
        checks++;
        if (app_ai_dmg && app_pl_dmg) begin
            errors++;
            $display("FAIL both_apply t=%0t got 11 want not both", $time);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, a, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        move_valid = 1'b0;
        move_in    = 2'b00;
        new_game   = 1'b0;
        p_hp       = 4'd15;
        AI_hp      = 4'd15;
        accu       = 4'd0;
        roll       = 4'd0;
        tick(2);
        chk("rst_ready", move_ready, 1);
        chk("rst_pmove", p_move, 0);
        chk("rst_turn", turn_cnt, 0);
        chk("rst_over", game_over, 0);
        chk("rst_aid", app_ai_dmg, 0);

        // Normal turn, both hit
        rst = 1'b0; accu = 4'd12; roll = 4'd3;
        move_in = 2'b10; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        chk("nt_load", load_ai_hp, 1);
        chk("nt_pmove", p_move, 2);
        tick(2);
        chk("nt_aid", app_ai_dmg, 1);
        tick(4);
        chk("nt_pld", app_pl_dmg, 1);
        tick(2);
        chk("nt_ready", move_ready, 1);
        chk("nt_turn", turn_cnt, 1);

        // All miss reaches the turn limit with equal HP
        accu = 4'd0; roll = 4'd5; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        tick(5);
        chk("tl_over", game_over, 1);
        chk("tl_draw", draw, 1);
        chk("tl_win", winner, 0);
        chk("tl_turn", turn_cnt, 2);
        tick(3);
        chk("tl_hold", game_over, 1);
        new_game = 1'b1; tick(1); new_game = 1'b0;
        chk("ng_ready", move_ready, 1);
        chk("ng_turn", turn_cnt, 0);

        // KO of the AI in the player half-turn
        accu = 4'd12; roll = 4'd3; AI_hp = 4'd0;
        move_in = 2'b01; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        tick(4);
        chk("ko_over", game_over, 1);
        chk("ko_win", winner, 1);
        chk("ko_pld", app_pl_dmg, 0);
        new_game = 1'b1; tick(1); new_game = 1'b0;
        chk("ko_ready", move_ready, 1);
        chk("ko_turn", turn_cnt, 0);

        // move_valid during AI eval is ignored
        AI_hp = 4'd15; move_in = 2'b01; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        tick(5);
        chk("ig_stop", stop, 1);
        chk("ig_actr", actr, 1);
        move_in = 2'b11; move_valid = 1'b1;
        tick(1); move_valid = 1'b0; move_in = 2'b01;
        chk("ig_pmove", p_move, 1);
        tick(2);
        chk("ig_ready", move_ready, 1);

        // Timeout after four idle cycles takes move 00
        tick(3);
        chk("to_wait", move_ready, 1);
        tick(1);
        chk("to_load", load_ai_hp, 1);
        chk("to_pmove", p_move, 0);
        tick(8);
        chk("to_over", game_over, 1);
        chk("to_draw", draw, 1);
        new_game = 1'b1; tick(1); new_game = 1'b0;

        // Reset during the AI damage strobe
        move_in = 2'b10; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        tick(2);
        chk("mr_aid", app_ai_dmg, 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_aid0", app_ai_dmg, 0);
        chk("mr_ready", move_ready, 1);
        chk("mr_pmove", p_move, 0);
        chk("mr_hit", hit, 0);
        tick(1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mr_quiet", {load_ai_hp, app_ai_dmg, app_pl_dmg}, 0);
        end
        move_in = 2'b11; move_valid = 1'b1;
        tick(1); move_valid = 1'b0;
        chk("mr_load", load_ai_hp, 1);
        chk("mr_pmove3", p_move, 3);
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
